// File: rtl/uart_top_tx.sv
// rtl/uart_top_tx.sv - UART transmitter: 8N/8E with 1 or 2 stop bits, programmable baud divisor
module uart_top_tx #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_en,
  input  logic [DIV_W-1:0]  baud_divisor,
  input  logic              parity_sel,
  input  logic              stop_sel,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int FRAME_W = DATA_W + 4;
  localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_nxt;
  logic [FRAME_W-1:0] shift_reg;
  logic [DIV_W-1:0]   baud_cnt;
  logic [DIV_W-1:0]   div_eff;
  logic [3:0]         bit_cnt;
  logic [3:0]         last_bit;
  logic               done_q;
  logic               baud_tick;
  logic               frame_end;
  logic               handshake;

  assign div_eff = (baud_divisor == '0) ? DIV_ONE : baud_divisor;
  // >= keeps the counter bounded if the divisor shrinks mid-bit
  assign baud_tick = (state == SHIFT) && (baud_cnt >= div_eff - DIV_ONE);
  assign frame_end = baud_tick && (bit_cnt == last_bit);
  assign tx_done   = done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tx_ready  = 1'b0;
    tx        = 1'b1;
    tx_busy   = 1'b0;
    handshake = 1'b0;
    case (state)
      IDLE: begin
        tx_ready  = tx_en && !reset;
        handshake = tx_valid && tx_en && !reset;
        if (handshake) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        tx      = shift_reg[0];
        tx_busy = 1'b1;
        if (frame_end) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '1;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      last_bit  <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= frame_end;
      if (handshake) begin
        // Unused parity slot is filled with 1 so it reads as the first stop bit
        shift_reg <= {2'b11, (parity_sel ? ^tx_data : 1'b1), tx_data, 1'b0};
        baud_cnt  <= '0;
        bit_cnt   <= '0;
        last_bit  <= 4'd9 + {3'b000, parity_sel} + {3'b000, stop_sel};
      end else if (state == SHIFT) begin
        if (baud_tick) begin
          baud_cnt  <= '0;
          shift_reg <= {1'b1, shift_reg[FRAME_W-1:1]};
          bit_cnt   <= bit_cnt + 4'd1;
        end else begin
          baud_cnt <= baud_cnt + DIV_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_top_tx.sv
// tb/tb_uart_top_tx.sv - self-checking bench for uart_top_tx against a frame-list reference model
module tb_uart_top_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_en;
  logic [11:0] baud_divisor;
  logic        parity_sel;
  logic        stop_sel;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx;
  logic        tx_busy;
  logic        tx_done;

  int checks = 0;
  int errors = 0;

  uart_top_tx dut (
    .clk          (clk),
    .reset        (reset),
    .tx_en        (tx_en),
    .baud_divisor (baud_divisor),
    .parity_sel   (parity_sel),
    .stop_sel     (stop_sel),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line: list of frame bits, each held for max(div,1) cycles
  task automatic send_frame(input logic [7:0] d, input int div, input bit par, input bit stp,
                            input int drop_bit, input int rst_bit);
    bit exp_q[$];
    int dv;
    int n;
    dv = (div == 0) ? 1 : div;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (par) exp_q.push_back(^d);
    exp_q.push_back(1'b1);
    if (stp) exp_q.push_back(1'b1);

    baud_divisor = div[11:0];
    parity_sel   = par;
    stop_sel     = stp;
    tx_data      = d;
    tx_valid     = 1'b1;
    #1;
    n = 0;
    while (tx_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("ready_before_%02h", d), tx_ready, 1);
    if (tx_ready !== 1'b1) begin
      tx_valid = 1'b0;
      return;
    end
    @(negedge clk);
    tx_valid   = 1'b0;
    tx_data    = 8'($urandom);
    parity_sel = 1'($urandom);
    stop_sel   = 1'($urandom);
    for (int b = 0; b < exp_q.size(); b++) begin
      for (int c = 0; c < dv; c++) begin
        if (b > 0 || c > 0) @(negedge clk);
        chk($sformatf("tx_%02h_bit%0d_c%0d", d, b, c), tx, exp_q[b]);
        chk($sformatf("busy_%02h_bit%0d", d, b), tx_busy, 1);
        chk($sformatf("done_%02h_bit%0d", d, b), tx_done, 0);
        chk($sformatf("ready_%02h_bit%0d", d, b), tx_ready, 0);
        if (b == drop_bit && c == dv / 2) tx_en = 1'b0;
        if (b == rst_bit) begin
          reset = 1'b1;
          #1;
          chk("rst_tx", tx, 1);
          chk("rst_busy", tx_busy, 0);
          chk("rst_ready", tx_ready, 0);
          chk("rst_done", tx_done, 0);
          return;
        end
      end
    end
    @(negedge clk);
    chk($sformatf("done_pulse_%02h", d), tx_done, 1);
    chk($sformatf("idle_tx_%02h", d), tx, 1);
    chk($sformatf("idle_busy_%02h", d), tx_busy, 0);
    chk($sformatf("idle_ready_%02h", d), tx_ready, tx_en);
  endtask

  initial begin
    reset        = 1'b1;
    tx_en        = 1'b1;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    baud_divisor = 12'd4;
    parity_sel   = 1'b0;
    stop_sel     = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_ready", tx_ready, 0);
    chk("reset_busy", tx_busy, 0);
    chk("reset_done", tx_done, 0);
    reset = 1'b0;
    #1;
    chk("post_reset_ready", tx_ready, 1);

    send_frame(8'h55, 4, 1'b0, 1'b0, -1, -1);
    @(negedge clk);
    chk("done_one_cycle", tx_done, 0);

    send_frame(8'h07, 3, 1'b1, 1'b1, -1, -1);
    send_frame(8'hA5, 3, 1'b1, 1'b1, -1, -1);

    send_frame(8'h3C, 2, 1'b0, 1'b0, -1, -1);
    send_frame(8'hC3, 2, 1'b0, 1'b0, -1, -1);

    send_frame(8'h6A, 3, 1'b0, 1'b0, 4, -1);
    tx_valid = 1'b1;
    tx_data  = 8'h99;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("en_low_ready", tx_ready, 0);
      chk("en_low_tx", tx, 1);
      chk("en_low_busy", tx_busy, 0);
    end
    tx_en = 1'b1;
    send_frame(8'h99, 3, 1'b0, 1'b1, -1, -1);

    send_frame(8'h5A, 4, 1'b1, 1'b0, -1, 9);
    @(negedge clk);
    chk("rst_hold_tx", tx, 1);
    chk("rst_hold_ready", tx_ready, 0);
    reset = 1'b0;
    #1;
    chk("rst_release_ready", tx_ready, 1);
    send_frame(8'h81, 4, 1'b1, 1'b1, -1, -1);

    send_frame(8'hF0, 0, 1'b1, 1'b0, -1, -1);
    send_frame(8'hF0, 1, 1'b1, 1'b0, -1, -1);

    for (int k = 0; k < 10; k++) begin
      send_frame(8'($urandom), int'($urandom_range(0, 5)), 1'($urandom), 1'($urandom), -1, -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_top_tx.md
Name: uart_top_tx

Overview:
UART transmitter top and the transmit counterpart of the existing UART receive top. It accepts one byte per valid/ready handshake and serialises it LSB-first onto tx. Each frame is one start bit, 8 data bits, an optional even-parity bit and 1 or 2 stop bits. Bit timing comes from a programmable baud divisor that matches the receive side.

Parameters:
DATA_W, 8, data bits per frame (fixed at 8; the frame counter is sized for a 12-bit maximum frame)
DIV_W, 12, baud_divisor width

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
tx_en  input  1  transmitter enable; gates acceptance of new frames only
baud_divisor  input  12  clock cycles per bit; a value of 0 is treated as 1
parity_sel  input  1  1 = append even-parity bit after data bit 7
stop_sel  input  1  0 = one stop bit, 1 = two stop bits
tx_data  input  8  byte to send
tx_valid  input  1  tx_data valid
tx_ready  output  1  block can accept a byte this cycle
tx  output  1  serial line, idles high
tx_busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset values: while reset is high, tx=1, tx_ready=0, tx_busy=0 and tx_done=0. The FSM is forced to IDLE and all counters are cleared. Reset mid-frame aborts the frame and drives tx high immediately (asynchronous).
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - tx=1, tx_busy=0, tx_ready=tx_en.
  - A handshake is tx_valid && tx_ready at a rising edge.
  - On handshake, latch tx_data, parity_sel and stop_sel into a frame shift register. Mid-frame changes to these inputs are ignored.
  - Compute parity = XOR of the 8 data bits.
  - Clear the baud counter and bit counter, then enter SHIFT.
- Frame shift register contents (LSB first): bit0=0 (start), bits1-8=data[0..7], then parity bit if enabled, then stop bit(s)=1.
- Frame length L = 10 + parity_sel + stop_sel (range 10..12).
- SHIFT:
  - tx = current LSB of the shift register. tx_busy=1, tx_ready=0.
  - The baud counter counts 0..max(baud_divisor,1)-1. On the terminal count it wraps to 0 and emits baud_tick.
  - On baud_tick: shift the register right, filling with 1, and increment the bit counter (4 bits).
  - When baud_tick occurs and the bit counter == L-1, return to IDLE and pulse tx_done for the first IDLE cycle.
- Latency: the start bit appears on tx in the cycle after the handshake edge. Each bit lasts exactly max(baud_divisor,1) cycles. The last stop bit ends, and tx_done/tx_ready rise, exactly L*div cycles after the start bit begins.
- Back-to-back: tx_ready is high in the tx_done cycle. A handshake in that cycle starts the next start bit one cycle later, so the minimum inter-frame idle is 1 cycle.
- tx_en deasserted mid-frame: the current frame completes normally. tx_ready stays 0 afterwards until tx_en returns.
- tx_valid while busy is ignored. The byte is not captured, and upstream must hold tx_valid until the handshake.
- baud_divisor change mid-frame takes effect at the next baud counter wrap. Behaviour is defined but not recommended.
- No combinational path from tx_valid to tx_ready.

Test Plan:
- div=4, parity_sel=0, stop_sel=0, send 0x55:
  - tx sequence 0,1,0,1,0,1,0,1,0,1, each bit exactly 4 cycles.
  - tx_done pulses 40 cycles after the start bit begins.
  - tx_busy high for 40 cycles.
- div=3, parity_sel=1, stop_sel=1, send 0x07:
  - bits 0,1,1,1,0,0,0,0,0, parity 1, stop 1,1.
  - 12 bits, 36 cycles.
  - Send 0xA5 with the same settings: parity bit 0.
- Back-to-back: hold tx_valid with 0x3C, then present 0xC3 in the tx_done cycle, div=2.
  - Exactly 1 idle-high cycle between the stop bit of frame 1 and the start bit of frame 2.
  - Both bytes are correct on the line.
- tx_en dropped in the middle of data bit 3:
  - frame finishes intact and tx_done pulses.
  - tx_ready stays 0 with tx_valid=1 and no new frame starts until tx_en=1.
- Assert reset during parity bit: tx=1 immediately, and tx_busy, tx_ready and tx_done are 0. After release with tx_en=1, tx_ready=1 and a fresh frame with 0x81 transmits correctly.
- baud_divisor=0 and =1:
  - each bit lasts 1 cycle.
  - 0xF0 with parity enabled gives 11 single-cycle bits with parity 0.
